// File: rtl/pds_pwr_seq.sv
// pds_pwr_seq: port power-up sequencer / shedder behind the PDS allocator.
// Powers granted+detected ports one at a time, highest priority first, with a
// programmable inrush stagger between enables. On a budget overload it sheds
// the lowest-priority enabled port, one per pass, with a holdoff afterwards.
//
// Ports:
//   clk, rst_n    clock (rising edge), async active-low reset
//   req_on        allocator grant per port
//   det           valid PD detected per port
//   prio          2-bit priority per port at [2i+1:2i], 3 = highest
//   stagger_cyc   WAIT length loaded after each enable or shed
//   overload      level, measured power above budget
//   ports_off     level, global kill (top precedence)
//   en            registered per-port power enables
//   cur_port      index of the port last selected or shed
//   busy          FSM not in IDLE
//   shed_pulse    one-cycle pulse when a port is shed
module pds_pwr_seq #(
    parameter int NUM_PORTS = 4,
    parameter int STAGGER_W = 8,
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PORTS-1:0]   req_on,
    input  logic [NUM_PORTS-1:0]   det,
    input  logic [2*NUM_PORTS-1:0] prio,
    input  logic [STAGGER_W-1:0]   stagger_cyc,
    input  logic                   overload,
    input  logic                   ports_off,
    output logic [NUM_PORTS-1:0]   en,
    output logic [IW-1:0]          cur_port,
    output logic                   busy,
    output logic                   shed_pulse
);

    typedef enum logic [2:0] {IDLE, SELECT, ENABLE, WAIT, SHED} state_t;

    state_t                 state, state_nxt;
    logic [NUM_PORTS-1:0]   en_nxt, pending;
    logic [IW-1:0]          cur_nxt, sel_idx, shed_idx;
    logic [STAGGER_W-1:0]   cnt, cnt_nxt;
    logic                   pulse_nxt;
    logic                   sel_found, shed_found;
    logic [1:0]             sel_prio, shed_prio;

    assign pending = req_on & det & ~en;
    assign busy    = (state != IDLE);

    // Enable pick: strictly-greater compare while scanning up keeps the
    // lowest index on ties. Shed pick: less-or-equal keeps the highest index.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_prio   = '0;
        shed_found = 1'b0;
        shed_idx   = '0;
        shed_prio  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pending[i] && (!sel_found || prio[2*i +: 2] > sel_prio)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                sel_prio  = prio[2*i +: 2];
            end
            if (en[i] && (!shed_found || prio[2*i +: 2] <= shed_prio)) begin
                shed_found = 1'b1;
                shed_idx   = IW'(i);
                shed_prio  = prio[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        // Grants or detections that go away drop the port silently.
        en_nxt    = en & req_on & det;
        cur_nxt   = cur_port;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        if (ports_off) begin
            en_nxt    = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (overload && en != '0)  state_nxt = SHED;
                    else if (pending != '0)    state_nxt = SELECT;
                end
                SELECT: begin
                    if (pending != '0) begin
                        cur_nxt   = sel_idx;
                        state_nxt = ENABLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                ENABLE: begin
                    if (pending[cur_port]) begin
                        en_nxt[cur_port] = 1'b1;
                        if (stagger_cyc == '0) begin
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt   = stagger_cyc;
                            state_nxt = WAIT;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                WAIT: begin
                    if (overload && en != '0) begin
                        state_nxt = SHED;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                        if (cnt == STAGGER_W'(1)) state_nxt = IDLE;
                    end
                end
                SHED: begin
                    if (en != '0) begin
                        cur_nxt          = shed_idx;
                        en_nxt[shed_idx] = 1'b0;
                        pulse_nxt        = 1'b1;
                        if (stagger_cyc == '0) begin
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt   = stagger_cyc;
                            state_nxt = WAIT;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            en         <= '0;
            cur_port   <= '0;
            cnt        <= '0;
            shed_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            en         <= en_nxt;
            cur_port   <= cur_nxt;
            cnt        <= cnt_nxt;
            shed_pulse <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_pds_pwr_seq.sv
// Directed bench for pds_pwr_seq. Inputs change and outputs are sampled 1ns
// after each rising edge; expected values are hand-derived edge counts.
module tb_pds_pwr_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_on, det;
    logic [7:0] prio;
    logic [7:0] stagger_cyc;
    logic       overload, ports_off;
    logic [3:0] en;
    logic [1:0] cur_port;
    logic       busy, shed_pulse;

    int total = 0;
    int bad   = 0;

    pds_pwr_seq #(.NUM_PORTS(4), .STAGGER_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_on(req_on), .det(det), .prio(prio),
        .stagger_cyc(stagger_cyc), .overload(overload), .ports_off(ports_off),
        .en(en), .cur_port(cur_port), .busy(busy), .shed_pulse(shed_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_on = '0; det = '0; prio = '0; stagger_cyc = '0;
        overload = 1'b0; ports_off = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // All four ports granted with zero stagger: one port every 3 edges.
    task automatic fill_all(input logic [7:0] p);
        prio = p; stagger_cyc = 8'd0; req_on = 4'hF; det = 4'hF;
        tick(12);
        chk("fill_en", en, 4'hF);
        chk("fill_idle", busy, 1'b0);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_en", en, 4'h0);
        chk("rst_cur", cur_port, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pulse", shed_pulse, 1'b0);

        // T1: priority order and stagger spacing
        stagger_cyc = 8'd4; det = 4'hF; req_on = 4'b0101; prio = 8'h31;
        tick(1);  chk("t1_busy", busy, 1'b1);
        tick(2);  chk("t1_en2", en, 4'b0100);
        chk("t1_cur2", cur_port, 2'd2);
        tick(6);  chk("t1_gap", en, 4'b0100);
        tick(1);  chk("t1_en0", en, 4'b0101);
        chk("t1_cur0", cur_port, 2'd0);
        tick(3);  chk("t1_wait", busy, 1'b1);
        tick(1);  chk("t1_done", busy, 1'b0);

        // T2: single overload sheds lowest prio, highest index on tie
        do_reset();
        fill_all(8'h83);
        overload = 1'b1;
        tick(1);  chk("t2_pre_en", en, 4'hF);
        chk("t2_pre_pulse", shed_pulse, 1'b0);
        overload = 1'b0;
        tick(1);  chk("t2_en", en, 4'b1011);
        chk("t2_cur", cur_port, 2'd2);
        chk("t2_pulse", shed_pulse, 1'b1);
        tick(1);  chk("t2_pulse_off", shed_pulse, 1'b0);
        chk("t2_en_hold", en, 4'b1011);

        // T3: held overload sheds p2, p1, p3, p0 with pulses 2 edges apart
        do_reset();
        fill_all(8'h83);
        stagger_cyc = 8'd2; overload = 1'b1;
        tick(2);  chk("t3_en_a", en, 4'b1011);
        chk("t3_pulse_a", shed_pulse, 1'b1);
        tick(1);  chk("t3_gap_a", shed_pulse, 1'b0);
        tick(1);  chk("t3_en_b", en, 4'b1001);
        chk("t3_cur_b", cur_port, 2'd1);
        tick(2);  chk("t3_en_c", en, 4'b0001);
        chk("t3_cur_c", cur_port, 2'd3);
        tick(2);  chk("t3_en_d", en, 4'b0000);
        chk("t3_cur_d", cur_port, 2'd0);
        chk("t3_pulse_d", shed_pulse, 1'b1);
        tick(1);  chk("t3_no_more", shed_pulse, 1'b0);
        chk("t3_holdoff", busy, 1'b1);
        overload = 1'b0; req_on = '0;
        tick(1);  chk("t3_idle", busy, 1'b0);

        // T4: global kill during WAIT
        do_reset();
        stagger_cyc = 8'd10; det = 4'hF; req_on = 4'b0011; prio = 8'h00;
        tick(3);  chk("t4_en0", en, 4'b0001);
        tick(13); chk("t4_en1", en, 4'b0011);
        tick(2);  chk("t4_in_wait", busy, 1'b1);
        ports_off = 1'b1;
        tick(1);  chk("t4_en", en, 4'b0000);
        chk("t4_busy", busy, 1'b0);
        chk("t4_pulse", shed_pulse, 1'b0);
        tick(1);  chk("t4_held", busy, 1'b0);
        ports_off = 1'b0;
        tick(1);  chk("t4_resume", busy, 1'b1);

        // T5: detection drop is silent and leaves the wait running
        do_reset();
        stagger_cyc = 8'd5; det = 4'hF; req_on = 4'b0010;
        tick(3);  chk("t5_en", en, 4'b0010);
        tick(1);
        det = 4'b1101;
        tick(1);  chk("t5_drop", en, 4'b0000);
        chk("t5_pulse", shed_pulse, 1'b0);
        chk("t5_busy", busy, 1'b1);
        tick(2);  chk("t5_wait_end", busy, 1'b1);
        tick(1);  chk("t5_idle", busy, 1'b0);

        // T6: async reset mid-WAIT, then back-to-back enables
        do_reset();
        stagger_cyc = 8'd20; det = 4'hF; req_on = 4'b0110;
        tick(3);  chk("t6_en1", en, 4'b0010);
        tick(23); chk("t6_en2", en, 4'b0110);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("t6_async_en", en, 4'b0000);
        chk("t6_async_busy", busy, 1'b0);
        stagger_cyc = 8'd0; req_on = 4'hF;
        tick(1);
        rst_n = 1'b1;
        tick(2);  chk("t6_b2b_0a", en, 4'b0000);
        tick(1);  chk("t6_b2b_0", en, 4'b0001);
        tick(3);  chk("t6_b2b_1", en, 4'b0011);
        tick(3);  chk("t6_b2b_2", en, 4'b0111);
        tick(3);  chk("t6_b2b_3", en, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
